// File: rtl/route4_ctrl_pkg.sv
// route4_ctrl shared definitions: word width, channel codes, mode codes.
// Optional round-robin scheduling is enabled by defining ROUTE4_RR_EN.
package route4_ctrl_pkg;
    localparam int WORD_W = 16;
    localparam int NUM_CH = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        ch_t;

    localparam ch_t CH_A = 2'd0;
    localparam ch_t CH_B = 2'd1;
    localparam ch_t CH_C = 2'd2;
    localparam ch_t CH_D = 2'd3;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;
endpackage

// File: rtl/route4_ctrl_if.sv
// route4_ctrl bus: producer handshake, four consumer channels, debug pointer.
// The mode signal exists only when ROUTE4_RR_EN is defined.
interface route4_ctrl_if;
    import route4_ctrl_pkg::*;

    word_t      in;
    ch_t        dest;
`ifdef ROUTE4_RR_EN
    logic       mode;
`endif
    logic       in_valid;
    logic       in_ready;
    word_t      a;
    word_t      b;
    word_t      c;
    word_t      d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    ch_t        rr_ptr;

`ifdef ROUTE4_RR_EN
    modport slave  (input  in, dest, mode, in_valid, out_ready,
                    output in_ready, a, b, c, d, out_valid, rr_ptr);
    modport master (output in, dest, mode, in_valid, out_ready,
                    input  in_ready, a, b, c, d, out_valid, rr_ptr);
`else
    modport slave  (input  in, dest, in_valid, out_ready,
                    output in_ready, a, b, c, d, out_valid, rr_ptr);
    modport master (output in, dest, in_valid, out_ready,
                    input  in_ready, a, b, c, d, out_valid, rr_ptr);
`endif
endinterface

// File: rtl/route4_ctrl_dmux.sv
// 1-to-4 demultiplexer (DMux4Way16 when W=16): the selected output carries
// the input, every other output is zero. Also used at W=1 as a decoder.
module route4_ctrl_dmux #(
    parameter int W = 16
) (
    input  logic [W-1:0] in,
    input  logic [1:0]   sel,
    output logic [W-1:0] out [4]
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            assign out[gi] = (sel == 2'(gi)) ? in : '0;
        end
    endgenerate
endmodule

// File: rtl/route4_ctrl.sv
// route4_ctrl: registered 4-way word router with valid/ready flow control.
// Each channel holds one word until its consumer takes it. Defining
// ROUTE4_RR_EN adds the mode input and the round-robin pointer.
module route4_ctrl
    import route4_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    route4_ctrl_if.slave  bus
);
    word_t      data_reg [4];
    logic [3:0] valid_reg;
    ch_t        rr_ptr_reg;
    ch_t        sel;
    logic       in_ready;
    logic       accept;
    word_t      steer [4];
    logic [0:0] load_arr [4];
    logic [3:0] load_en;

    // Effective select: pointer in round-robin mode, dest otherwise.
`ifdef ROUTE4_RR_EN
    assign sel = (bus.mode == MODE_DIRECTED) ? bus.dest : rr_ptr_reg;
`else
    assign sel = bus.dest;
`endif

    // Only the selected channel can stall the producer; held off during reset.
    assign in_ready = rst_n && (!valid_reg[sel] || bus.out_ready[sel]);
    assign accept   = bus.in_valid && in_ready;

    route4_ctrl_dmux #(.W(WORD_W)) u_data_dmux (
        .in  (bus.in),
        .sel (sel),
        .out (steer)
    );

    route4_ctrl_dmux #(.W(1)) u_load_dmux (
        .in  (accept),
        .sel (sel),
        .out (load_arr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_load
            assign load_en[gi] = load_arr[gi][0];
        end
    endgenerate

    // Channel registers: load wins over drain so a channel sustains 1 word/cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) data_reg[i] <= '0;
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load_en[i]) begin
                    data_reg[i]  <= steer[i];
                    valid_reg[i] <= 1'b1;
                end else if (bus.out_ready[i]) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ROUTE4_RR_EN
    // Pointer advances only on accepted round-robin words; never skips a full channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= CH_A;
        end else if (accept && (bus.mode == MODE_RR)) begin
            rr_ptr_reg <= rr_ptr_reg + 2'd1;
        end
    end
`else
    assign rr_ptr_reg = CH_A;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.a         = data_reg[CH_A];
    assign bus.b         = data_reg[CH_B];
    assign bus.c         = data_reg[CH_C];
    assign bus.d         = data_reg[CH_D];
    assign bus.out_valid = valid_reg;
    assign bus.rr_ptr    = rr_ptr_reg;
endmodule
